// File: rtl/mux_arbiter.sv
// Two-source round-robin arbiter in front of a shared WIDTH-bit mux, with a
// bounded burst length for fairness and a single registered output stage.
module mux_arbiter #(
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel_a,
    output logic             busy
);

    // Handshakes: a beat moves on any rising edge where valid && ready are both
    // high; ready never depends combinationally on the same port's valid.

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t           state_q, state_d;
    logic             last_a_q, last_a_d;
    logic [3:0]       burst_cnt_q, burst_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             can_load;
    logic             accept_a;
    logic             accept_b;
    logic [3:0]       cnt_inc;

    // The output register can take a new beat when empty or draining this cycle.
    assign can_load  = !out_valid_q || out_ready;
    assign a_ready   = (state_q == GNT_A) && can_load;
    assign b_ready   = (state_q == GNT_B) && can_load;
    assign accept_a  = a_valid && a_ready;
    assign accept_b  = b_valid && b_ready;
    assign cnt_inc   = burst_cnt_q + 4'd1;
    assign sel_a     = (state_q == GNT_A);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        last_a_d    = last_a_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_d = last_a_q ? GNT_B : GNT_A;
                end else if (a_valid) begin
                    state_d = GNT_A;
                end else if (b_valid) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (!a_valid) begin
                    burst_cnt_d = 4'd0;
                    last_a_d    = 1'b1;
                    state_d     = b_valid ? GNT_B : IDLE;
                end else if (a_ready) begin
                    // Limit only forces a hand-over when B is actually waiting.
                    if (cnt_inc == MAX_CNT) begin
                        burst_cnt_d = 4'd0;
                        if (b_valid) begin
                            state_d  = GNT_B;
                            last_a_d = 1'b1;
                        end
                    end else begin
                        burst_cnt_d = cnt_inc;
                    end
                end
            end
            GNT_B: begin
                if (!b_valid) begin
                    burst_cnt_d = 4'd0;
                    last_a_d    = 1'b0;
                    state_d     = a_valid ? GNT_A : IDLE;
                end else if (b_ready) begin
                    if (cnt_inc == MAX_CNT) begin
                        burst_cnt_d = 4'd0;
                        if (a_valid) begin
                            state_d  = GNT_A;
                            last_a_d = 1'b0;
                        end
                    end else begin
                        burst_cnt_d = cnt_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_a) begin
            out_valid_d = 1'b1;
            out_data_d  = a_data;
        end else if (accept_b) begin
            out_valid_d = 1'b1;
            out_data_d  = b_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_a_q    <= 1'b0;
            burst_cnt_q <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_a_q    <= last_a_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter (WIDTH=8, MAX_BURST=4) with immediate
// assertions at every comparison point.
module tb_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic [7:0] a_data;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_data;
    logic       b_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       sel_a;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // Sources present base+n, where n counts beats already accepted.
    logic [7:0] a_base, b_base;
    int         a_n, b_n;
    logic [7:0] exp_q[$];

    mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel_a(sel_a), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic acc_a, acc_b;
        #1;
        acc_a = rst_n && a_valid && a_ready;
        acc_b = rst_n && b_valid && b_ready;
        @(posedge clk);
        #2;
        if (acc_a) a_n++;
        if (acc_b) b_n++;
        a_data = a_base + 8'(a_n);
        b_data = b_base + 8'(b_n);
        #1;
    endtask

    task automatic set_a(input logic [7:0] base);
        a_base = base; a_n = 0; a_data = base;
    endtask

    task automatic set_b(input logic [7:0] base);
        b_base = base; b_n = 0; b_data = base;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        set_a(8'h00); set_b(8'h00);
        do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sel_a", sel_a, 0);
        check("rst_busy", busy, 0);
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        rst_n = 1'b1;

        // Single uncontested source: one bubble, then 1 beat/cycle, no limit.
        set_a(8'h11); a_valid = 1'b1;
        #1;
        check("t1_idle_a_ready", a_ready, 0);
        cyc();
        check("t1_sel_a", sel_a, 1);
        check("t1_busy", busy, 1);
        check("t1_no_out_yet", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t1_out_valid", out_valid, 1);
            check("t1_out_data", out_data, 32'h11 + 32'(i));
            check("t1_stay_a", sel_a, 1);
        end
        a_valid = 1'b0;
        cyc();
        check("t1_back_idle", busy, 0);
        check("t1_drain", out_valid, 0);

        // Both requesting from reset: A first (last=B), bursts of 4, no bubble.
        do_reset();
        set_a(8'hA0); set_b(8'hB0);
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hB0 + 8'(i));
        for (int i = 4; i < 8; i++) exp_q.push_back(8'hA0 + 8'(i));
        cyc();
        check("t2_first_grant_a", sel_a, 1);
        check("t2_bubble", out_valid, 0);
        for (int k = 0; k < 12; k++) begin
            logic [7:0] e;
            int edge_n;
            cyc();
            e = exp_q.pop_front();
            edge_n = k + 2;
            check("t2_out_valid", out_valid, 1);
            check("t2_out_data", out_data, e);
            check("t2_sel_a", sel_a, (edge_n <= 4) || (edge_n >= 9 && edge_n <= 12));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        cyc();
        check("t2_idle", busy, 0);

        // Tie after A released alone: B wins.
        do_reset();
        set_a(8'h30); set_b(8'h40);
        a_valid = 1'b1; b_valid = 1'b1;
        cyc();
        check("t5_tie_a", sel_a, 1);
        b_valid = 1'b0;
        cyc();
        check("t5_a_beat", out_data, 8'h30);
        a_valid = 1'b0;
        cyc();
        check("t5_released", busy, 0);
        a_valid = 1'b1; b_valid = 1'b1;
        cyc();
        check("t5_tie_b", sel_a, 0);
        check("t5_tie_b_busy", busy, 1);
        check("t5_b_ready", b_ready, 1);
        cyc();
        check("t5_b_beat", out_data, 8'h40);
        a_valid = 1'b0; b_valid = 1'b0;
        cyc();
        check("t5_idle", busy, 0);

        // A drops after 2 beats while B waits: immediate switch, fresh burst count.
        set_a(8'h60); a_valid = 1'b1;
        cyc();
        check("t4_grant_a", sel_a, 1);
        cyc();
        cyc();
        check("t4_second_a", out_data, 8'h61);
        a_valid = 1'b0; b_valid = 1'b1; set_b(8'h70);
        cyc();
        check("t4_switch_b", sel_a, 0);
        check("t4_busy", busy, 1);
        check("t4_b_ready", b_ready, 1);
        check("t4_no_beat", out_valid, 0);
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t4_b_out", out_data, 32'h70 + 32'(i));
        end
        check("t4_full_b_burst_then_a", sel_a, 1);

        // Back-pressure holds the output register and blocks A.
        b_valid = 1'b0; set_a(8'h5A);
        cyc();
        check("t3_load", out_data, 8'h5A);
        out_ready = 1'b0;
        #1;
        check("t3_a_blocked", a_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_hold_data", out_data, 8'h5A);
            check("t3_hold_valid", out_valid, 1);
            check("t3_a_ready", a_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("t3_ready_same_cycle", a_ready, 1);
        cyc();
        check("t3_next_beat", out_data, 8'h5B);

        // Reset mid-burst with a pending beat drops it.
        rst_n = 1'b0;
        cyc();
        check("t6_out_valid", out_valid, 0);
        check("t6_out_data", out_data, 0);
        check("t6_busy", busy, 0);
        check("t6_a_ready", a_ready, 0);
        check("t6_b_ready", b_ready, 0);
        rst_n = 1'b1;
        #1;
        check("t6_idle_after", a_ready, 0);
        cyc();
        check("t6_resume_grant", sel_a, 1);
        check("t6_no_beat", out_valid, 0);
        cyc();
        check("t6_resume_data", out_data, 8'h5C);
        check("t6_resume_valid", out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
